// File: rtl/axi_write_burst_if.sv
// ---------------------------------------------------------------------------
// axi_write_burst_if
//   Bundles the AXI-Stream sink and the AXI4 write-channel signals of the
//   burst write master.
//
//   master modport : the write master's view (stream in, AXI write out)
//   slave  modport : the opposite side (stream source plus AXI write slave)
//
//   Stream : S_WR_tdata, S_WR_tvalid, S_WR_tready
//   AW     : m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid,ready}
//   W      : m_axi_w{data,strb,last,valid,ready}
//   B      : m_axi_b{id,resp,valid,ready}
// ---------------------------------------------------------------------------
interface axi_write_burst_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
);
    // Stream side
    logic [DATA_WIDTH-1:0]   S_WR_tdata;
    logic                    S_WR_tvalid;
    logic                    S_WR_tready;

    // Write address channel
    logic                    m_axi_awid;
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [7:0]              m_axi_awlen;
    logic [2:0]              m_axi_awsize;
    logic [1:0]              m_axi_awburst;
    logic                    m_axi_awlock;
    logic [3:0]              m_axi_awcache;
    logic [2:0]              m_axi_awprot;
    logic [3:0]              m_axi_awqos;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;

    // Write data channel
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wlast;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;

    // Write response channel
    logic                    m_axi_bid;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport master (
        input  S_WR_tdata, S_WR_tvalid,
        output S_WR_tready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output S_WR_tdata, S_WR_tvalid,
        input  S_WR_tready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );

endinterface

// File: rtl/axi_write_burst.sv
// ---------------------------------------------------------------------------
// axi_write_burst
//   Single-outstanding AXI4 write master. Each frame on the stream becomes one
//   fixed-length INCR burst of WR_LIN beats; burst start addresses step by
//   WR_STEP through a ring of WR_LIMIT bytes. After the B handshake a one-cycle
//   o_wr_done pulse is produced (start trigger for the matching read master).
//
//   Ports
//     M_WR_aclk   : clock for stream and AXI
//     M_WR_areset : synchronous, active-high reset
//     bus         : stream sink + AXI4 write channels (master modport)
//     o_wr_done   : one-cycle pulse per completed burst
//     o_wr_err    : sticky, set by any non-OKAY bresp, cleared by reset only
// ---------------------------------------------------------------------------
module axi_write_burst #(
    parameter int unsigned     WR_FLIP_BYTE  = 0,
    parameter int unsigned     WR_ADDR_WIDTH = 32,
    parameter int unsigned     WR_DATA_WIDTH = 64,
    parameter int unsigned     WR_LIN        = 16,
    parameter longint unsigned WR_STEP       = 4096,
    parameter longint unsigned WR_LIMIT      = 32'h10000
) (
    input  logic              M_WR_aclk,
    input  logic              M_WR_areset,
    axi_write_burst_if.master bus,
    output logic              o_wr_done,
    output logic              o_wr_err
);

    localparam int unsigned            NumBytes   = WR_DATA_WIDTH / 8;
    localparam logic [2:0]             AwSize     = 3'($clog2(NumBytes));
    localparam logic [7:0]             LastBeat   = 8'(WR_LIN - 1);
    localparam logic [WR_ADDR_WIDTH-1:0] AddrStep = WR_ADDR_WIDTH'(WR_STEP);
    // Last legal burst start inside the ring; anything at or past it wraps to 0.
    localparam logic [WR_ADDR_WIDTH-1:0] AddrWrapAt = WR_ADDR_WIDTH'(WR_LIMIT - WR_STEP);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StResp,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic                      awvalid_q;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic [WR_ADDR_WIDTH-1:0]  wr_addr_buff_q, wr_addr_buff_d;
    logic                      err_q, err_d;

    logic                      is_last;
    logic                      w_hs;
    logic                      b_hs;
    logic [WR_DATA_WIDTH-1:0]  flipped;
    logic [WR_DATA_WIDTH-1:0]  stream_word;
    logic                      unused_bid;

    assign unused_bid = bus.m_axi_bid;

    // Byte-reversed copy of the stream word; selected by WR_FLIP_BYTE.
    for (genvar i = 0; i < NumBytes; i++) begin : g_flip
        assign flipped[8*i +: 8] = bus.S_WR_tdata[8*(NumBytes-1-i) +: 8];
    end

    assign stream_word = (WR_FLIP_BYTE != 0) ? flipped : bus.S_WR_tdata;

    assign is_last = (beat_cnt_q == LastBeat);
    assign w_hs    = (state_q == StData) && bus.S_WR_tvalid && bus.m_axi_wready;
    assign b_hs    = (state_q == StResp) && bus.m_axi_bvalid;

    // ---------------------------------------------------------------- FSM --
    always_ff @(posedge M_WR_aclk) begin
        if (M_WR_areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.S_WR_tvalid)                   state_d = StAddr;
            StAddr:  if (awvalid_q && bus.m_axi_awready)    state_d = StData;
            StData:  if (w_hs && is_last)                   state_d = StResp;
            StResp:  if (bus.m_axi_bvalid)                  state_d = StDone;
            StDone:                                         state_d = StIdle;
            default:                                        state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.S_WR_tready  = 1'b0;
        bus.m_axi_wvalid = 1'b0;
        bus.m_axi_wlast  = 1'b0;
        bus.m_axi_wdata  = '0;
        bus.m_axi_bready = 1'b0;
        o_wr_done        = 1'b0;
        unique case (state_q)
            StData: begin
                // Stream and W channel are joined combinationally so a beat
                // moves only when both sides agree in the same cycle.
                bus.S_WR_tready  = bus.m_axi_wready;
                bus.m_axi_wvalid = bus.S_WR_tvalid;
                bus.m_axi_wlast  = is_last;
                bus.m_axi_wdata  = stream_word;
            end
            StResp:  bus.m_axi_bready = 1'b1;
            StDone:  o_wr_done        = 1'b1;
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath --
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_d == StDone) begin
            beat_cnt_d = '0;
        end else if (w_hs) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    always_comb begin
        wr_addr_buff_d = wr_addr_buff_q;
        if (state_q == StDone) begin
            wr_addr_buff_d = (wr_addr_buff_q >= AddrWrapAt) ? '0 : wr_addr_buff_q + AddrStep;
        end
    end

    // Folded in at the B handshake so the flag is already visible in DONE.
    always_comb begin
        err_d = err_q;
        if (b_hs && (bus.m_axi_bresp != 2'b00)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge M_WR_aclk) begin
        if (M_WR_areset) begin
            awvalid_q      <= 1'b0;
            beat_cnt_q     <= '0;
            wr_addr_buff_q <= '0;
            err_q          <= 1'b0;
        end else begin
            // High for exactly the cycles spent in ADDR, dropping with awready.
            awvalid_q      <= (state_d == StAddr);
            beat_cnt_q     <= beat_cnt_d;
            wr_addr_buff_q <= wr_addr_buff_d;
            err_q          <= err_d;
        end
    end

    // ------------------------------------------------------- AW constants --
    // awaddr only moves in DONE, so it is stable while awvalid is high.
    assign bus.m_axi_awid    = 1'b0;
    assign bus.m_axi_awaddr  = wr_addr_buff_q;
    assign bus.m_axi_awlen   = LastBeat;
    assign bus.m_axi_awsize  = AwSize;
    assign bus.m_axi_awburst = 2'd1;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = 4'd3;
    assign bus.m_axi_awprot  = 3'd0;
    assign bus.m_axi_awqos   = 4'd0;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wstrb   = '1;

    assign o_wr_err = err_q;

endmodule

// File: tb/tb_axi_write_burst.sv
// ---------------------------------------------------------------------------
// tb_axi_write_burst
//   dut0: default parameters (16-beat bursts, no flip).
//   dut1: WR_FLIP_BYTE = 1, WR_LIN = 1.
//   Stimulus pushes expected AW addresses, W beats and error flags into
//   queues; per-DUT monitors pop and compare whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_axi_write_burst;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;

    localparam logic [31:0] RING [17] = '{
        32'h0000, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000, 32'h6000, 32'h7000,
        32'h8000, 32'h9000, 32'hA000, 32'hB000, 32'hC000, 32'hD000, 32'hE000, 32'hF000,
        32'h0000
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_write_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    axi_write_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    logic done0, err0, done1, err1;

    axi_write_burst #(
        .WR_ADDR_WIDTH (AW),
        .WR_DATA_WIDTH (DW)
    ) dut0 (
        .M_WR_aclk   (clk),
        .M_WR_areset (rst),
        .bus         (bus0.master),
        .o_wr_done   (done0),
        .o_wr_err    (err0)
    );

    axi_write_burst #(
        .WR_FLIP_BYTE  (1),
        .WR_ADDR_WIDTH (AW),
        .WR_DATA_WIDTH (DW),
        .WR_LIN        (1)
    ) dut1 (
        .M_WR_aclk   (clk),
        .M_WR_areset (rst),
        .bus         (bus1.master),
        .o_wr_done   (done1),
        .o_wr_err    (err1)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard queues
    logic [63:0] src0_q[$];
    logic [63:0] src1_q[$];
    logic [63:0] exp_aw0[$];
    logic [63:0] exp_aw1[$];
    logic [63:0] exp_wd0[$];
    logic [63:0] exp_wd1[$];
    logic        exp_wl0[$];
    logic        exp_err0[$];
    logic [1:0]  bresp0_q[$];

    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int wbeats0   = 0;
    bit bp        = 1'b0;

    // ------------------------------------------------- dut0 stream source --
    initial begin : src0_drv
        logic hs;
        bus0.S_WR_tvalid = 1'b0;
        bus0.S_WR_tdata  = '0;
        forever begin
            @(negedge clk);
            hs = bus0.S_WR_tvalid && bus0.S_WR_tready;
            @(posedge clk);
            #1;
            if (rst) begin
                bus0.S_WR_tvalid = 1'b0;
                bus0.S_WR_tdata  = '0;
            end else begin
                if (hs && src0_q.size() != 0) void'(src0_q.pop_front());
                // A presented beat stays presented until it is taken.
                if (!(bus0.S_WR_tvalid && !hs)) begin
                    if (src0_q.size() != 0 && (!bp || $urandom_range(0, 3) != 0)) begin
                        bus0.S_WR_tvalid = 1'b1;
                        bus0.S_WR_tdata  = src0_q[0];
                    end else begin
                        bus0.S_WR_tvalid = 1'b0;
                        bus0.S_WR_tdata  = '0;
                    end
                end
            end
        end
    end

    // -------------------------------------------------- dut0 AXI slave -----
    initial begin : slv0_drv
        logic wl_hs, b_hs, bpend;
        bpend              = 1'b0;
        bus0.m_axi_awready = 1'b0;
        bus0.m_axi_wready  = 1'b0;
        bus0.m_axi_bvalid  = 1'b0;
        bus0.m_axi_bresp   = 2'b00;
        bus0.m_axi_bid     = 1'b0;
        forever begin
            @(negedge clk);
            wl_hs = bus0.m_axi_wvalid && bus0.m_axi_wready && bus0.m_axi_wlast;
            b_hs  = bus0.m_axi_bvalid && bus0.m_axi_bready;
            @(posedge clk);
            #1;
            if (rst) begin
                bus0.m_axi_awready = 1'b0;
                bus0.m_axi_wready  = 1'b0;
                bus0.m_axi_bvalid  = 1'b0;
                bus0.m_axi_bresp   = 2'b00;
                bpend              = 1'b0;
            end else begin
                if (wl_hs) bpend = 1'b1;
                if (b_hs) bus0.m_axi_bvalid = 1'b0;
                if (bpend && !bus0.m_axi_bvalid && (!bp || $urandom_range(0, 2) == 0)) begin
                    bus0.m_axi_bvalid = 1'b1;
                    bus0.m_axi_bresp  = (bresp0_q.size() != 0) ? bresp0_q.pop_front() : 2'b00;
                    bpend             = 1'b0;
                end
                bus0.m_axi_awready = !bp || ($urandom_range(0, 2) != 0);
                bus0.m_axi_wready  = !bp || ($urandom_range(0, 2) != 0);
            end
        end
    end

    // ------------------------------------------------------ dut0 monitor ---
    initial begin : mon0
        logic        aw_open, aw_hold, prev_b, prev_awv;
        logic [63:0] aw_snap, e;
        int          since_b;
        aw_open = 1'b0; aw_hold = 1'b0; prev_b = 1'b0; prev_awv = 1'b0;
        aw_snap = '0;   since_b = 100;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_open = 1'b0; aw_hold = 1'b0; prev_b = 1'b0; prev_awv = 1'b0;
                since_b = 100;
            end else begin
                if (aw_hold)
                    chk("aw_stable", {19'd0, bus0.m_axi_awaddr, bus0.m_axi_awlen,
                        bus0.m_axi_awsize, bus0.m_axi_awburst}, aw_snap);
                if (bus0.m_axi_wvalid) chk("w_after_aw", 64'(aw_open), 64'd1);
                if (bus0.m_axi_awvalid && !prev_awv) chk("aw_gap_ok", 64'(since_b >= 2), 64'd1);
                if (bus0.m_axi_awvalid && bus0.m_axi_awready) begin
                    e = (exp_aw0.size() != 0) ? exp_aw0.pop_front() : 'x;
                    chk("awaddr", 64'(bus0.m_axi_awaddr), e);
                    chk("awlen", 64'(bus0.m_axi_awlen), 64'd15);
                    chk("awsize", 64'(bus0.m_axi_awsize), 64'd3);
                    chk("awburst", 64'(bus0.m_axi_awburst), 64'd1);
                    aw_open = 1'b1;
                end
                if (bus0.m_axi_wvalid && bus0.m_axi_wready) begin
                    e = (exp_wd0.size() != 0) ? exp_wd0.pop_front() : 'x;
                    chk("wdata", bus0.m_axi_wdata, e);
                    e = (exp_wl0.size() != 0) ? 64'(exp_wl0.pop_front()) : 'x;
                    chk("wlast", 64'(bus0.m_axi_wlast), e);
                    wbeats0++;
                    if (bus0.m_axi_wlast) aw_open = 1'b0;
                end
                if (prev_b || done0) chk("done_pulse", 64'(done0), 64'(prev_b));
                if (done0) begin
                    done_cnt0++;
                    e = (exp_err0.size() != 0) ? 64'(exp_err0.pop_front()) : 'x;
                    chk("wr_err", 64'(err0), e);
                end
                aw_hold  = bus0.m_axi_awvalid && !bus0.m_axi_awready;
                aw_snap  = {19'd0, bus0.m_axi_awaddr, bus0.m_axi_awlen,
                            bus0.m_axi_awsize, bus0.m_axi_awburst};
                prev_awv = bus0.m_axi_awvalid;
                prev_b   = bus0.m_axi_bvalid && bus0.m_axi_bready;
                if (prev_b) since_b = 0;
                else if (since_b < 100) since_b++;
            end
        end
    end

    // ---------------------------------------- dut1 source + always-ready slave
    initial begin : drv1
        logic s_hs, wl_hs, b_hs;
        bus1.S_WR_tvalid   = 1'b0;
        bus1.S_WR_tdata    = '0;
        bus1.m_axi_awready = 1'b1;
        bus1.m_axi_wready  = 1'b1;
        bus1.m_axi_bvalid  = 1'b0;
        bus1.m_axi_bresp   = 2'b00;
        bus1.m_axi_bid     = 1'b0;
        forever begin
            @(negedge clk);
            s_hs  = bus1.S_WR_tvalid && bus1.S_WR_tready;
            wl_hs = bus1.m_axi_wvalid && bus1.m_axi_wready && bus1.m_axi_wlast;
            b_hs  = bus1.m_axi_bvalid && bus1.m_axi_bready;
            @(posedge clk);
            #1;
            if (rst) begin
                bus1.S_WR_tvalid  = 1'b0;
                bus1.m_axi_bvalid = 1'b0;
            end else begin
                if (s_hs && src1_q.size() != 0) void'(src1_q.pop_front());
                bus1.S_WR_tvalid = (src1_q.size() != 0);
                bus1.S_WR_tdata  = (src1_q.size() != 0) ? src1_q[0] : '0;
                if (b_hs) bus1.m_axi_bvalid = 1'b0;
                if (wl_hs) bus1.m_axi_bvalid = 1'b1;
            end
        end
    end

    initial begin : mon1
        logic        aw_open;
        logic [63:0] e;
        aw_open = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_open = 1'b0;
            end else begin
                if (bus1.m_axi_wvalid) chk("w1_after_aw", 64'(aw_open), 64'd1);
                if (bus1.m_axi_awvalid && bus1.m_axi_awready) begin
                    e = (exp_aw1.size() != 0) ? exp_aw1.pop_front() : 'x;
                    chk("awaddr1", 64'(bus1.m_axi_awaddr), e);
                    chk("awlen1", 64'(bus1.m_axi_awlen), 64'd0);
                    aw_open = 1'b1;
                end
                if (bus1.m_axi_wvalid && bus1.m_axi_wready) begin
                    e = (exp_wd1.size() != 0) ? exp_wd1.pop_front() : 'x;
                    chk("wdata_flip", bus1.m_axi_wdata, e);
                    chk("wlast1", 64'(bus1.m_axi_wlast), 64'd1);
                    aw_open = 1'b0;
                end
                if (done1) done_cnt1++;
            end
        end
    end

    // ------------------------------------------------------------ helpers --
    task automatic push_burst0(input logic [31:0] addr, input int tag,
                               input logic [1:0] bresp, input logic exp_err);
        logic [63:0] w;
        exp_aw0.push_back(64'(addr));
        for (int k = 0; k < 16; k++) begin
            w = {32'hC0DE_0000 | 32'(tag), 32'(k) * 32'h0101_0101};
            src0_q.push_back(w);
            exp_wd0.push_back(w);
            exp_wl0.push_back(k == 15);
        end
        bresp0_q.push_back(bresp);
        exp_err0.push_back(exp_err);
    endtask

    task automatic wait_done0(input int target, input int budget);
        int n = 0;
        while (done_cnt0 < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done0_count", 64'(done_cnt0), 64'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, 64'(bus0.m_axi_awvalid), 64'd0);
        chk({tag, "_wvalid"},  64'(bus0.m_axi_wvalid),  64'd0);
        chk({tag, "_wlast"},   64'(bus0.m_axi_wlast),   64'd0);
        chk({tag, "_bready"},  64'(bus0.m_axi_bready),  64'd0);
        chk({tag, "_tready"},  64'(bus0.S_WR_tready),   64'd0);
        chk({tag, "_done"},    64'(done0),              64'd0);
        chk({tag, "_err"},     64'(err0),               64'd0);
        chk({tag, "_awaddr"},  64'(bus0.m_axi_awaddr),  64'd0);
        chk({tag, "_wdata"},   bus0.m_axi_wdata,        64'd0);
    endtask

    // --------------------------------------------------------------- main --
    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");

        // Single burst and address ring: 17 bursts, no stalls.
        for (int b = 0; b < 17; b++) push_burst0(RING[b], b, 2'b00, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_done0(17, 3000);

        // Backpressure everywhere; SLVERR on the second burst, flag stays set.
        bp = 1'b1;
        push_burst0(32'h1000, 17, 2'b00, 1'b0);
        push_burst0(32'h2000, 18, 2'b10, 1'b1);
        push_burst0(32'h3000, 19, 2'b00, 1'b1);
        push_burst0(32'h4000, 20, 2'b00, 1'b1);
        wait_done0(21, 8000);
        bp = 1'b0;

        // Reset after beat 7 of the next burst.
        n = wbeats0;
        push_burst0(32'h5000, 21, 2'b00, 1'b0);
        for (int i = 0; i < 500 && wbeats0 < n + 7; i++) begin
            @(posedge clk);
            #2;
        end
        chk("beats_before_reset", 64'(wbeats0), 64'(n + 7));
        rst = 1'b1;
        src0_q.delete();
        exp_aw0.delete();
        exp_wd0.delete();
        exp_wl0.delete();
        exp_err0.delete();
        bresp0_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_burst0(32'h0000, 22, 2'b00, 1'b0);
        wait_done0(22, 2000);

        // Byte flip with one-beat bursts on dut1.
        src1_q.push_back(64'h0011_2233_4455_6677); exp_wd1.push_back(64'h7766_5544_3322_1100);
        src1_q.push_back(64'hDEAD_BEEF_0123_4567); exp_wd1.push_back(64'h6745_2301_EFBE_ADDE);
        src1_q.push_back(64'h8000_0000_0000_0001); exp_wd1.push_back(64'h0100_0000_0000_0080);
        exp_aw1.push_back(64'h0000);
        exp_aw1.push_back(64'h1000);
        exp_aw1.push_back(64'h2000);
        n = 0;
        while (done_cnt1 < 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("done1_count", 64'(done_cnt1), 64'd3);

        repeat (4) @(posedge clk);
        chk("aw0_drained", 64'(exp_aw0.size()), 64'd0);
        chk("w0_drained",  64'(exp_wd0.size()), 64'd0);
        chk("w1_drained",  64'(exp_wd1.size()), 64'd0);
        chk("aw1_drained", 64'(exp_aw1.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
